// File: rtl/fc_classifier_if.sv
// fc_classifier_if -- bundle of the fc_classifier handshake, weight-ROM and
// result signals.
//   slave  : the classifier itself (takes features and weights, drives results)
//   master : the environment (upstream conv stage, weight ROM, result consumer)
// Optional feature macro: FC_BIAS_EN adds the in_bias vector
// (slot o at [o*ACC_WIDTH +: ACC_WIDTH]).
interface fc_classifier_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_IN       = 48,
  parameter int NUM_OUT      = 10,
  parameter int ACC_WIDTH    = 32,
  parameter int W_ADDR_WIDTH = 9,
  parameter int IDX_WIDTH    = 4
);
  logic                          in_valid;
  logic [DATA_WIDTH*NUM_IN-1:0]  in_features;
  logic                          in_ready;
`ifdef FC_BIAS_EN
  logic [ACC_WIDTH*NUM_OUT-1:0]  in_bias;
`endif
  logic                          w_rd_en;
  logic [W_ADDR_WIDTH-1:0]       w_addr;
  logic [DATA_WIDTH-1:0]         w_data;
  logic [ACC_WIDTH*NUM_OUT-1:0]  scores;
  logic [IDX_WIDTH-1:0]          class_idx;
  logic                          out_valid;
  logic                          busy;
  logic                          overrun;

`ifdef FC_BIAS_EN
  modport slave (
    input  in_valid, in_features, in_bias, w_data,
    output in_ready, w_rd_en, w_addr, scores, class_idx, out_valid, busy, overrun
  );
  modport master (
    output in_valid, in_features, in_bias, w_data,
    input  in_ready, w_rd_en, w_addr, scores, class_idx, out_valid, busy, overrun
  );
`else
  modport slave (
    input  in_valid, in_features, w_data,
    output in_ready, w_rd_en, w_addr, scores, class_idx, out_valid, busy, overrun
  );
  modport master (
    output in_valid, in_features, w_data,
    input  in_ready, w_rd_en, w_addr, scores, class_idx, out_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/fc_classifier.sv
// fc_classifier -- fully-connected output layer of the CNN datapath.
// Captures a NUM_IN-feature vector, streams NUM_IN*NUM_OUT signed weights from a
// synchronous ROM (one cycle read latency), MACs them into NUM_OUT scores and
// reports all scores plus the argmax class index with a one-cycle out_valid.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : fc_classifier_if.slave -- in_valid/in_features/in_ready (input
//          vector), w_rd_en/w_addr/w_data (weight ROM), scores/class_idx/
//          out_valid (results), busy, overrun (sticky dropped-vector flag)
// Optional feature macro: FC_BIAS_EN -- when defined, in_bias is captured with
// the features and preloads each output's accumulator.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a vector, in_ready=1
// S_RUN   | issuing one weight read per cycle, addresses 0..NUM_IN*NUM_OUT-1
// S_DRAIN | last weight returns; last score and argmax finalise
// S_DONE  | out_valid pulse; a new vector may be accepted here
module fc_classifier #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_IN       = 48,
  parameter int NUM_OUT      = 10,
  parameter int ACC_WIDTH    = 32,
  parameter int W_ADDR_WIDTH = 9,
  parameter int IDX_WIDTH    = 4
) (
  input logic          clk,
  input logic          rst,
  fc_classifier_if.slave bus
);
  localparam int TOTAL = NUM_IN * NUM_OUT;
  localparam int IW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic                        in_ready;
  logic                        accept;
  logic [W_ADDR_WIDTH-1:0]     run_left_q;
  logic [W_ADDR_WIDTH-1:0]     addr_q;
  logic [IW-1:0]               i_cnt_q;
  logic [IDX_WIDTH-1:0]        o_cnt_q;
  // Index of the weight currently on w_data (reads delayed by the ROM latency)
  logic                        rd_vld_q;
  logic [IW-1:0]               rd_i_q;
  logic [IDX_WIDTH-1:0]        rd_o_q;

  logic signed [DATA_WIDTH-1:0]   feat_q [NUM_IN];
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    buf_q [NUM_OUT];
  logic signed [ACC_WIDTH-1:0]    score_q [NUM_OUT];
  logic signed [ACC_WIDTH-1:0]    best_q;
  logic [IDX_WIDTH-1:0]           best_idx_q;
  logic [IDX_WIDTH-1:0]           class_q;
  logic                           overrun_q;

  logic signed [DATA_WIDTH-1:0]   f_cur;
  logic signed [DATA_WIDTH-1:0]   w_cur;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [ACC_WIDTH-1:0]    row_init;
  logic signed [ACC_WIDTH-1:0]    first_init;
  logic                           row_end;
  logic                           new_best;
  logic [IDX_WIDTH-1:0]           o_nxt;
  logic [ACC_WIDTH*NUM_OUT-1:0]   scores_flat;

`ifdef FC_BIAS_EN
  logic signed [ACC_WIDTH-1:0]    bias_q [NUM_OUT];
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_RUN;
      S_RUN:   if (run_left_q == '0) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = bus.in_valid ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept   = in_ready && bus.in_valid;

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.out_valid = (state_q == S_DONE);
  // Decoded straight from the state register so reset removes it at once
  assign bus.w_rd_en   = (state_q == S_RUN);
  assign bus.w_addr    = addr_q;
  assign bus.overrun   = overrun_q;
  assign bus.class_idx = class_q;

  // ---------------- read sequencing ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_left_q <= '0;
      addr_q     <= '0;
      i_cnt_q    <= '0;
      o_cnt_q    <= '0;
      rd_vld_q   <= 1'b0;
      rd_i_q     <= '0;
      rd_o_q     <= '0;
    end else begin
      rd_vld_q <= (state_q == S_RUN);
      rd_i_q   <= i_cnt_q;
      rd_o_q   <= o_cnt_q;
      if (accept) begin
        run_left_q <= W_ADDR_WIDTH'(TOTAL - 1);
        addr_q     <= '0;
        i_cnt_q    <= '0;
        o_cnt_q    <= '0;
      end else if (state_q == S_RUN) begin
        if (run_left_q != '0) begin
          run_left_q <= run_left_q - 1'b1;
          addr_q     <= addr_q + 1'b1;
        end else begin
          addr_q     <= '0;
        end
        if (i_cnt_q == IW'(NUM_IN - 1)) begin
          i_cnt_q <= '0;
          o_cnt_q <= (o_cnt_q == IDX_WIDTH'(NUM_OUT - 1)) ? '0 : o_cnt_q + 1'b1;
        end else begin
          i_cnt_q <= i_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------- MAC datapath ----------------
  always_comb begin
    f_cur    = feat_q[rd_i_q];
    w_cur    = bus.w_data;
    prod     = f_cur * w_cur;
    prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    acc_sum  = acc_q + prod_ext;
    row_end  = rd_vld_q && (rd_i_q == IW'(NUM_IN - 1));
    // Output 0 always seeds the running best; later outputs need strictly greater
    new_best = (rd_o_q == '0) || (acc_sum > best_q);
    o_nxt    = rd_o_q + 1'b1;
`ifdef FC_BIAS_EN
    row_init   = (rd_o_q == IDX_WIDTH'(NUM_OUT - 1)) ? '0 : bias_q[o_nxt];
    first_init = bus.in_bias[ACC_WIDTH-1:0];
`else
    row_init   = '0;
    first_init = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_IN; i++) feat_q[i] <= '0;
      for (int o = 0; o < NUM_OUT; o++) begin
        buf_q[o]   <= '0;
        score_q[o] <= '0;
`ifdef FC_BIAS_EN
        bias_q[o]  <= '0;
`endif
      end
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_IN; i++)
          feat_q[i] <= bus.in_features[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef FC_BIAS_EN
        for (int o = 0; o < NUM_OUT; o++)
          bias_q[o] <= bus.in_bias[o*ACC_WIDTH +: ACC_WIDTH];
`endif
        acc_q <= first_init;
      end else if (rd_vld_q) begin
        if (row_end) begin
          buf_q[rd_o_q] <= acc_sum;
          acc_q         <= row_init;
          if (new_best) begin
            best_q     <= acc_sum;
            best_idx_q <= rd_o_q;
          end
        end else begin
          acc_q <= acc_sum;
        end
      end
      // Publish everything at once so scores and class_idx change only with out_valid
      if (state_q == S_DRAIN) begin
        for (int o = 0; o < NUM_OUT; o++)
          score_q[o] <= (o == NUM_OUT - 1) ? acc_sum : buf_q[o];
        class_q <= new_best ? rd_o_q : best_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             overrun_q <= 1'b0;
    else if (bus.in_valid && !in_ready)   overrun_q <= 1'b1;
  end

  always_comb begin
    scores_flat = '0;
    for (int o = 0; o < NUM_OUT; o++)
      scores_flat[o*ACC_WIDTH +: ACC_WIDTH] = score_q[o];
  end
  assign bus.scores = scores_flat;

endmodule

// File: tb/tb_fc_classifier.sv
// tb_fc_classifier -- self-checking bench for fc_classifier.
// Drives vectors through the interface, models the weight ROM, and compares
// results against a loop-based reference of the fully-connected layer.
`timescale 1ns/1ps
module tb_fc_classifier;
  localparam int DW = 8, NIN = 48, NOUT = 10, ACCW = 32, IW = 4;
  localparam int TOTAL = NIN * NOUT;
  localparam int LIMIT = 700;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_classifier_if bus ();
  fc_classifier dut (.clk(clk), .rst(rst), .bus(bus));

  logic signed [DW-1:0] feats [NIN];
  logic signed [DW-1:0] rom [TOTAL];
  int bias [NOUT];
  int exp_sc [NOUT];
  int exp_idx;
  int n_cmp = 0;
  int n_err = 0;

  logic [ACCW*NOUT-1:0] obs_sc, obs_early;
  logic [IW-1:0] obs_idx;
  int rd_count, rd_first, rd_last, ov_count, ov_cycle;
  logic busy_c1, ready_c1;
  longint addr_sum;

  // Synchronous weight ROM; garbage on w_data whenever no read was issued
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_data <= rom[int'(bus.w_addr)];
    else             bus.w_data <= DW'($urandom);
  end

  task automatic drive_inputs();
    for (int i = 0; i < NIN; i++) bus.in_features[i*DW +: DW] = feats[i];
`ifdef FC_BIAS_EN
    for (int o = 0; o < NOUT; o++) bus.in_bias[o*ACCW +: ACCW] = bias[o];
`endif
  endtask

  task automatic fill(input int fv, input int wv);
    for (int i = 0; i < NIN; i++) feats[i] = DW'(fv);
    for (int a = 0; a < TOTAL; a++) rom[a] = DW'(wv);
    for (int o = 0; o < NOUT; o++) bias[o] = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NIN; i++) feats[i] = DW'($urandom);
    for (int a = 0; a < TOTAL; a++) rom[a] = DW'($urandom);
    for (int o = 0; o < NOUT; o++) bias[o] = 0;
  endtask

  // Reference: score[o] = bias[o] + sum_i feat[i]*w[o*NIN+i]; first maximum wins
  task automatic compute_expected();
    for (int o = 0; o < NOUT; o++) begin
      int s;
      s = bias[o];
      for (int i = 0; i < NIN; i++) s += int'(feats[i]) * int'(rom[o*NIN + i]);
      exp_sc[o] = s;
    end
    exp_idx = 0;
    for (int o = 1; o < NOUT; o++) if (exp_sc[o] > exp_sc[exp_idx]) exp_idx = o;
  endtask

  // Caller raises in_valid before a rising edge; that edge is cycle 0, and the
  // negedge preceding edge c is sampled as cycle c. Returns in the out_valid cycle.
  task automatic collect(input int inject);
    rd_count = 0; rd_first = -1; rd_last = -1; ov_count = 0; ov_cycle = -1;
    addr_sum = 0; busy_c1 = 1'b0; ready_c1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clk);
      if (bus.w_rd_en === 1'b1) begin
        rd_count++;
        if (rd_first < 0) rd_first = c;
        rd_last = c;
        addr_sum += longint'(bus.w_addr);
      end
      if (c == 1) begin
        busy_c1 = bus.busy; ready_c1 = bus.in_ready; obs_early = bus.scores;
      end
      if (bus.out_valid === 1'b1) begin
        ov_count++; ov_cycle = c; obs_sc = bus.scores; obs_idx = bus.class_idx;
        break;
      end
      if (c == 1) bus.in_valid = 1'b0;
      if (c == inject) begin
        bus.in_valid = 1'b1;
        for (int i = 0; i < NIN; i++) bus.in_features[i*DW +: DW] = DW'($urandom);
      end
      if (c == inject + 1) begin
        bus.in_valid = 1'b0;
        drive_inputs();
      end
    end
  endtask

  task automatic start_vector();
    drive_inputs();
    bus.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.in_valid = 1'b0; fill(0, 0); drive_inputs();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.w_rd_en !== 1'b0) begin n_err++; $display("FAIL reset w_rd_en: got %b want 0", bus.w_rd_en); end
    n_cmp++; if (bus.w_addr !== '0) begin n_err++; $display("FAIL reset w_addr: got %0d want 0", bus.w_addr); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset overrun: got %b want 0", bus.overrun); end
    n_cmp++; if (bus.class_idx !== '0) begin n_err++; $display("FAIL reset class_idx: got %0d want 0", bus.class_idx); end
    n_cmp++; if (bus.scores !== '0) begin n_err++; $display("FAIL reset scores: got %h want 0", bus.scores); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post-reset in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_all_ones();
    fill(1, 1); start_vector(); collect(-10);
    for (int o = 0; o < NOUT; o++) begin
      n_cmp++;
      if (obs_sc[o*ACCW +: ACCW] !== 32'd48) begin
        n_err++; $display("FAIL ones score[%0d]: got %0d want 48", o, $signed(obs_sc[o*ACCW +: ACCW]));
      end
    end
    n_cmp++; if (obs_idx !== 4'd0) begin n_err++; $display("FAIL ones class_idx: got %0d want 0", obs_idx); end
    n_cmp++; if (ov_cycle !== 482) begin n_err++; $display("FAIL ones out_valid cycle: got %0d want 482", ov_cycle); end
    n_cmp++; if (rd_first !== 1 || rd_last !== 480 || rd_count !== 480) begin
      n_err++; $display("FAIL ones w_rd_en window: got first %0d last %0d count %0d want 1 480 480", rd_first, rd_last, rd_count);
    end
    n_cmp++; if (addr_sum !== 64'd114960) begin n_err++; $display("FAIL ones address sum: got %0d want 114960", addr_sum); end
    n_cmp++; if (busy_c1 !== 1'b1 || ready_c1 !== 1'b0) begin
      n_err++; $display("FAIL ones run flags: got busy %b in_ready %b want 1 0", busy_c1, ready_c1);
    end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ones out_valid width: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_row7();
    fill(1, 1);
    for (int i = 0; i < NIN; i++) rom[7*NIN + i] = 8'sd2;
    start_vector(); collect(-10);
    for (int o = 0; o < NOUT; o++) begin
      n_cmp++;
      if ($signed(obs_sc[o*ACCW +: ACCW]) !== ((o == 7) ? 96 : 48)) begin
        n_err++; $display("FAIL row7 score[%0d]: got %0d want %0d", o, $signed(obs_sc[o*ACCW +: ACCW]), (o == 7) ? 96 : 48);
      end
    end
    n_cmp++; if (obs_idx !== 4'd7) begin n_err++; $display("FAIL row7 class_idx: got %0d want 7", obs_idx); end
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.scores !== obs_sc || bus.class_idx !== 4'd7) begin
      n_err++; $display("FAIL row7 hold: got idx %0d want 7 with scores unchanged", bus.class_idx);
    end
  endtask

  task automatic test_signed();
    fill(-128, 127);
    for (int i = 0; i < NIN; i++) rom[3*NIN + i] = -8'sd128;
    start_vector(); collect(-10);
    for (int o = 0; o < NOUT; o++) begin
      n_cmp++;
      if ($signed(obs_sc[o*ACCW +: ACCW]) !== ((o == 3) ? 786432 : -780288)) begin
        n_err++; $display("FAIL signed score[%0d]: got %0d want %0d", o, $signed(obs_sc[o*ACCW +: ACCW]), (o == 3) ? 786432 : -780288);
      end
    end
    n_cmp++; if (obs_idx !== 4'd3) begin n_err++; $display("FAIL signed class_idx: got %0d want 3", obs_idx); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      fill_random();
      compute_expected();
      start_vector(); collect(-10);
      for (int o = 0; o < NOUT; o++) begin
        n_cmp++;
        if (obs_sc[o*ACCW +: ACCW] !== 32'(exp_sc[o])) begin
          n_err++; $display("FAIL random%0d score[%0d]: got %0d want %0d", t, o, $signed(obs_sc[o*ACCW +: ACCW]), exp_sc[o]);
        end
      end
      n_cmp++; if (obs_idx !== IW'(exp_idx)) begin n_err++; $display("FAIL random%0d class_idx: got %0d want %0d", t, obs_idx, exp_idx); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_overrun_back_to_back();
    logic [ACCW*NOUT-1:0] first_sc;
    n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL overrun before drop: got %b want 0", bus.overrun); end
    fill_random(); compute_expected();
    start_vector(); collect(100);
    n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL overrun flag: got %b want 1", bus.overrun); end
    n_cmp++; if (ov_cycle !== 482) begin n_err++; $display("FAIL overrun out_valid cycle: got %0d want 482", ov_cycle); end
    for (int o = 0; o < NOUT; o++) begin
      n_cmp++;
      if (obs_sc[o*ACCW +: ACCW] !== 32'(exp_sc[o])) begin
        n_err++; $display("FAIL overrun score[%0d]: got %0d want %0d", o, $signed(obs_sc[o*ACCW +: ACCW]), exp_sc[o]);
      end
    end
    n_cmp++; if (obs_idx !== IW'(exp_idx)) begin n_err++; $display("FAIL overrun class_idx: got %0d want %0d", obs_idx, exp_idx); end
    first_sc = obs_sc;
    // Still inside the DONE cycle: present the next vector now
    fill_random(); compute_expected();
    start_vector(); collect(-10);
    n_cmp++; if (obs_early !== first_sc) begin n_err++; $display("FAIL b2b scores held during run: got %h want %h", obs_early, first_sc); end
    n_cmp++; if (ov_cycle !== 482) begin n_err++; $display("FAIL b2b out_valid cycle: got %0d want 482", ov_cycle); end
    for (int o = 0; o < NOUT; o++) begin
      n_cmp++;
      if (obs_sc[o*ACCW +: ACCW] !== 32'(exp_sc[o])) begin
        n_err++; $display("FAIL b2b score[%0d]: got %0d want %0d", o, $signed(obs_sc[o*ACCW +: ACCW]), exp_sc[o]);
      end
    end
    n_cmp++; if (obs_idx !== IW'(exp_idx)) begin n_err++; $display("FAIL b2b class_idx: got %0d want %0d", obs_idx, exp_idx); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ov_seen;
    fill_random(); start_vector();
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) bus.in_valid = 1'b0;
    end
    n_cmp++; if (bus.w_rd_en !== 1'b1) begin n_err++; $display("FAIL midrst pre w_rd_en: got %b want 1", bus.w_rd_en); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (bus.w_rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst async drop: got rd %b busy %b ov %b want 0 0 0", bus.w_rd_en, bus.busy, bus.out_valid);
    end
    n_cmp++; if (bus.scores !== '0 || bus.class_idx !== '0) begin n_err++; $display("FAIL midrst results cleared: got idx %0d scores %h want 0", bus.class_idx, bus.scores); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL midrst overrun: got %b want 0", bus.overrun); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ov_seen = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ov_seen++;
    end
    n_cmp++; if (ov_seen !== 0) begin n_err++; $display("FAIL midrst stray out_valid: got %0d want 0", ov_seen); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst in_ready: got %b want 1", bus.in_ready); end
    fill_random(); compute_expected();
    start_vector(); collect(-10);
    n_cmp++; if (ov_cycle !== 482) begin n_err++; $display("FAIL midrst rerun out_valid cycle: got %0d want 482", ov_cycle); end
    for (int o = 0; o < NOUT; o++) begin
      n_cmp++;
      if (obs_sc[o*ACCW +: ACCW] !== 32'(exp_sc[o])) begin
        n_err++; $display("FAIL midrst rerun score[%0d]: got %0d want %0d", o, $signed(obs_sc[o*ACCW +: ACCW]), exp_sc[o]);
      end
    end
    n_cmp++; if (obs_idx !== IW'(exp_idx)) begin n_err++; $display("FAIL midrst rerun class_idx: got %0d want %0d", obs_idx, exp_idx); end
    repeat (2) @(negedge clk);
  endtask

`ifdef FC_BIAS_EN
  task automatic test_bias();
    fill_random();
    for (int i = 0; i < NIN; i++) feats[i] = '0;
    for (int o = 0; o < NOUT; o++) bias[o] = (o == 5) ? 1000 : -1;
    start_vector(); collect(-10);
    for (int o = 0; o < NOUT; o++) begin
      n_cmp++;
      if ($signed(obs_sc[o*ACCW +: ACCW]) !== ((o == 5) ? 1000 : -1)) begin
        n_err++; $display("FAIL bias score[%0d]: got %0d want %0d", o, $signed(obs_sc[o*ACCW +: ACCW]), (o == 5) ? 1000 : -1);
      end
    end
    n_cmp++; if (obs_idx !== 4'd5) begin n_err++; $display("FAIL bias class_idx: got %0d want 5", obs_idx); end
    repeat (2) @(negedge clk);
    fill_random();
    for (int o = 0; o < NOUT; o++) bias[o] = int'($urandom_range(0, 200000)) - 100000;
    compute_expected();
    start_vector(); collect(-10);
    for (int o = 0; o < NOUT; o++) begin
      n_cmp++;
      if (obs_sc[o*ACCW +: ACCW] !== 32'(exp_sc[o])) begin
        n_err++; $display("FAIL bias random score[%0d]: got %0d want %0d", o, $signed(obs_sc[o*ACCW +: ACCW]), exp_sc[o]);
      end
    end
    n_cmp++; if (obs_idx !== IW'(exp_idx)) begin n_err++; $display("FAIL bias random class_idx: got %0d want %0d", obs_idx, exp_idx); end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_row7();
    test_signed();
    test_random();
    test_overrun_back_to_back();
    test_reset_mid();
`ifdef FC_BIAS_EN
    test_bias();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
